// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared prescaled counter (edge- or centre-aligned)
// drives CHANNELS compare outputs whose duties are double-buffered and swap only at period start.
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PS_WIDTH = 8,
    parameter logic [CHANNELS-1:0] INVERT = {CHANNELS{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         center_mode,
    input  logic [PS_WIDTH-1:0]          prescale,
    input  logic [CHANNELS*WIDTH-1:0]    duty_data,
    input  logic                         duty_valid,
    output logic                         duty_ready,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_start,
    output logic [WIDTH-1:0]             cnt_out
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    localparam logic [WIDTH-1:0]    MAX    = '1;
    localparam logic [WIDTH-1:0]    ONE    = WIDTH'(1);
    localparam logic [PS_WIDTH-1:0] PS_ONE = PS_WIDTH'(1);

    logic [WIDTH-1:0]    cnt, cnt_step;
    logic [PS_WIDTH-1:0] pc, ps_shadow;
    logic                mode_shadow;
    dir_t                dir, dir_step;
    logic                running;
    logic                pending_full;
    logic [WIDTH-1:0]    active_duty  [CHANNELS];
    logic [WIDTH-1:0]    pending_duty [CHANNELS];
    logic [CHANNELS-1:0] raw;
    logic                tick, start, capture;

    assign tick       = (pc == ps_shadow);
    assign capture    = duty_valid & ~pending_full;
    assign duty_ready = ~pending_full;
    assign cnt_out    = cnt;

    // Next counter value on a tick; centre mode bounces at MAX and ends the period on reaching 0.
    always_comb begin
        cnt_step = cnt + ONE;
        dir_step = dir;
        if (mode_shadow) begin
            if (dir == DIR_UP) begin
                if (cnt == MAX) begin
                    cnt_step = MAX - ONE;
                    dir_step = DIR_DOWN;
                end
            end else begin
                cnt_step = cnt - ONE;
                if (cnt == ONE) begin
                    dir_step = DIR_UP;
                end
            end
        end
    end

    // A period begins on restart after idle/reset, or when a tick brings the counter back to 0.
    assign start = enable & (~running | (tick & (cnt_step == '0)));

    always_comb begin
        raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = (cnt < active_duty[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            pc           <= '0;
            dir          <= DIR_UP;
            ps_shadow    <= '0;
            mode_shadow  <= 1'b0;
            running      <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= INVERT;
        end else begin
            running      <= enable;
            period_start <= start;
            // The restart edge itself still shows idle, so stale duties never leak out.
            pwm_out      <= (enable & running) ? (raw ^ INVERT) : INVERT;
            if (!enable) begin
                cnt <= '0;
                pc  <= '0;
                dir <= DIR_UP;
            end else if (start) begin
                cnt         <= '0;
                pc          <= '0;
                dir         <= DIR_UP;
                ps_shadow   <= prescale;
                mode_shadow <= center_mode;
            end else if (tick) begin
                cnt <= cnt_step;
                pc  <= '0;
                dir <= dir_step;
            end else begin
                pc <= pc + PS_ONE;
            end
        end
    end

    // Only data already pending transfers at a start; a capture on that same edge waits a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_full <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                active_duty[i]  <= '0;
                pending_duty[i] <= '0;
            end
        end else begin
            if (start && pending_full) begin
                pending_full <= 1'b0;
                for (int i = 0; i < CHANNELS; i++) begin
                    active_duty[i] <= pending_duty[i];
                end
            end
            if (capture) begin
                pending_full <= 1'b1;
                for (int i = 0; i < CHANNELS; i++) begin
                    pending_duty[i] <= duty_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule
